// File: rtl/calc_if.sv
// ============================================================================
//  Module      : calc_if
//  Description : Keypad/display bundle between a calculator driver and
//                calc_engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface calc_if #(
    parameter int W = 8
);
    logic                key_valid;
    logic [3:0]          key;
    logic                clearEntry;
    logic signed [W-1:0] display;
    logic [1:0]          disp_src;
    logic [1:0]          state;
    logic                overflow;
    logic                zero;
    logic                entry_err;

    modport master (
        output key_valid, key, clearEntry,
        input  display, disp_src, state, overflow, zero, entry_err
    );

    modport slave (
        input  key_valid, key, clearEntry,
        output display, disp_src, state, overflow, zero, entry_err
    );
endinterface

`default_nettype wire

// File: rtl/calc_engine.sv
// ============================================================================
//  Module      : calc_engine
//  Description : Four-function-style keypad calculator core (add/sub, chaining,
//                repeat-equals) with decimal operand entry.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_engine #(
    parameter int W          = 8,
    parameter int MAX_DIGITS = 3
) (
    input  wire logic clock,
    input  wire logic clearAll,
    calc_if.slave     bus
);
    localparam int              CW      = $clog2(MAX_DIGITS + 1);
    localparam int              MW      = W + 4;
    localparam logic [W-1:0]    MAX_MAG = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        OP_WAIT = 2'd1,
        ENTER_B = 2'd2,
        RESULT  = 2'd3
    } state_t;

    state_t              st_q, st_d;
    logic signed [W-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic                op_q, op_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                err_q, err_d;

    // Digit entry datapath: works on whichever operand is being edited
    logic signed [W-1:0] w_entry;
    logic [W-1:0]        w_mag;
    logic [MW-1:0]       w_mag_ext, w_new_mag;
    logic signed [W-1:0] w_new_val;
    logic                w_digit_ok;
    logic signed [W-1:0] w_digit_val;

    assign w_entry     = (st_q == ENTER_B) ? b_q : a_q;
    assign w_mag       = w_entry[W-1] ? -w_entry : w_entry;
    assign w_mag_ext   = {4'b0000, w_mag};
    assign w_new_mag   = (w_mag_ext << 3) + (w_mag_ext << 1) + {{(MW-4){1'b0}}, bus.key};
    assign w_new_val   = w_entry[W-1] ? -w_new_mag[W-1:0] : w_new_mag[W-1:0];
    assign w_digit_ok  = (cnt_q < CW'(MAX_DIGITS)) && (w_new_mag <= {4'b0000, MAX_MAG});
    assign w_digit_val = {{(W-4){1'b0}}, bus.key};

    // Left operand is the running result when repeating equals
    logic signed [W-1:0] w_lhs, w_rhs, w_sum;
    logic                w_ovf;

    assign w_lhs = (st_q == RESULT) ? r_q : a_q;
    assign w_rhs = op_q ? -b_q : b_q;
    assign w_sum = w_lhs + w_rhs;
    assign w_ovf = (w_lhs[W-1] == w_rhs[W-1]) && (w_sum[W-1] != w_lhs[W-1]);

    logic w_is_digit, w_is_addsub, w_is_eq, w_is_neg, w_key_sub;

    assign w_is_digit  = (bus.key <= 4'd9);
    assign w_is_addsub = (bus.key == 4'hA) || (bus.key == 4'hB);
    assign w_is_eq     = (bus.key == 4'hD);
    assign w_is_neg    = (bus.key == 4'hE);
    assign w_key_sub   = (bus.key == 4'hB);

    always_ff @(posedge clock) begin
        if (clearAll) begin
            st_q  <= ENTER_A;
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            op_q  <= 1'b0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            a_q   <= a_d;
            b_q   <= b_d;
            r_q   <= r_d;
            op_q  <= op_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        st_d  = st_q;
        a_d   = a_q;
        b_d   = b_q;
        r_d   = r_q;
        op_d  = op_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        err_d = 1'b0;

        if (bus.clearEntry) begin
            ovf_d = 1'b0;
            cnt_d = '0;
            case (st_q)
                ENTER_A: a_d = '0;
                OP_WAIT, ENTER_B: begin
                    b_d  = '0;
                    st_d = OP_WAIT;
                end
                default: begin
                    st_d = ENTER_A;
                    a_d  = '0;
                    b_d  = '0;
                    r_d  = '0;
                    op_d = 1'b0;
                end
            endcase
        end else if (bus.key_valid) begin
            case (st_q)
                ENTER_A, ENTER_B: begin
                    if (w_is_digit) begin
                        ovf_d = 1'b0;
                        if (w_digit_ok) begin
                            cnt_d = cnt_q + CW'(1);
                            if (st_q == ENTER_A) a_d = w_new_val;
                            else                 b_d = w_new_val;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (w_is_neg && (w_entry != '0)) begin
                        if (st_q == ENTER_A) a_d = -a_q;
                        else                 b_d = -b_q;
                    end else if (w_is_addsub) begin
                        op_d  = w_key_sub;
                        st_d  = OP_WAIT;
                        cnt_d = '0;
                        if (st_q == ENTER_B) begin
                            r_d   = w_sum;
                            a_d   = w_sum;
                            ovf_d = w_ovf;
                        end
                    end else if (w_is_eq && (st_q == ENTER_B)) begin
                        r_d   = w_sum;
                        ovf_d = w_ovf;
                        st_d  = RESULT;
                    end
                end
                OP_WAIT: begin
                    if (w_is_digit) begin
                        b_d   = w_digit_val;
                        cnt_d = CW'(1);
                        ovf_d = 1'b0;
                        st_d  = ENTER_B;
                    end else if (w_is_addsub) begin
                        op_d = w_key_sub;
                    end
                end
                default: begin
                    if (w_is_eq) begin
                        r_d   = w_sum;
                        ovf_d = w_ovf;
                    end else if (w_is_addsub) begin
                        a_d  = r_q;
                        op_d = w_key_sub;
                        st_d = OP_WAIT;
                    end else if (w_is_digit) begin
                        a_d   = w_digit_val;
                        b_d   = '0;
                        r_d   = '0;
                        cnt_d = CW'(1);
                        ovf_d = 1'b0;
                        st_d  = ENTER_A;
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.display  = a_q;
        bus.disp_src = 2'd0;
        case (st_q)
            ENTER_B: begin
                bus.display  = b_q;
                bus.disp_src = 2'd1;
            end
            RESULT: begin
                bus.display  = r_q;
                bus.disp_src = 2'd2;
            end
            default: ;
        endcase
    end

    assign bus.state     = st_q;
    assign bus.overflow  = ovf_q;
    assign bus.entry_err = err_q;
    assign bus.zero      = (bus.display == '0);

endmodule

`default_nettype wire

// File: tb/tb_calc_engine.sv
// ============================================================================
//  Module      : tb_calc_engine
//  Description : Scoreboard bench for calc_engine with an integer reference
//                calculator model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_engine;
    localparam int W    = 8;
    localparam int MAXD = 3;
    localparam int MAXV = (1 << (W-1)) - 1;
    localparam int MINV = -(1 << (W-1));

    logic clk = 1'b0;
    logic clearAll = 1'b1;

    calc_if #(.W(W)) bus ();

    calc_engine #(.W(W), .MAX_DIGITS(MAXD)) dut (
        .clock    (clk),
        .clearAll (clearAll),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int disp;
        int src;
        int st;
        int ovf;
        int err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference calculator state (plain integers, real signed values)
    int mA, mB, mR, mop, mst, mcnt, movf, merr;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int wrap(input int x);
        int m;
        int y;
        m = 1 << W;
        y = x % m;
        if (y < 0) y += m;
        if (y > MAXV) y -= m;
        return y;
    endfunction

    task automatic m_reset();
        mA = 0; mB = 0; mR = 0; mop = 0; mst = 0; mcnt = 0; movf = 0; merr = 0;
    endtask

    task automatic m_compute(input int lhs, output int res);
        int raw;
        raw  = (mop == 1) ? lhs - mB : lhs + mB;
        movf = (raw > MAXV || raw < MINV) ? 1 : 0;
        res  = wrap(raw);
    endtask

    task automatic m_digit(inout int cur, input int d);
        int mag;
        int nv;
        movf = 0;
        mag  = (cur < 0) ? -cur : cur;
        nv   = mag * 10 + d;
        if (mcnt >= MAXD || nv > MAXV) begin
            merr = 1;
        end else begin
            cur = (cur < 0) ? -nv : nv;
            mcnt++;
        end
    endtask

    task automatic m_step(input bit ca, input bit ce, input bit kv, input int k);
        int res;
        bit is_dig, is_as, is_eq, is_neg;
        merr   = 0;
        is_dig = (k <= 9);
        is_as  = (k == 10 || k == 11);
        is_eq  = (k == 13);
        is_neg = (k == 14);
        if (ca) begin
            m_reset();
        end else if (ce) begin
            if (mst == 0) begin
                mA = 0; mcnt = 0; movf = 0;
            end else if (mst == 3) begin
                m_reset();
            end else begin
                mB = 0; mcnt = 0; movf = 0; mst = 1;
            end
        end else if (kv) begin
            case (mst)
                0: begin
                    if (is_dig) m_digit(mA, k);
                    else if (is_neg && mA != 0) mA = -mA;
                    else if (is_as) begin mop = k - 10; mst = 1; mcnt = 0; end
                end
                1: begin
                    if (is_dig) begin mB = k; mcnt = 1; movf = 0; mst = 2; end
                    else if (is_as) mop = k - 10;
                end
                2: begin
                    if (is_dig) m_digit(mB, k);
                    else if (is_neg && mB != 0) mB = -mB;
                    else if (is_eq) begin m_compute(mA, res); mR = res; mst = 3; end
                    else if (is_as) begin
                        m_compute(mA, res);
                        mR = res; mA = res; mop = k - 10; mst = 1; mcnt = 0;
                    end
                end
                default: begin
                    if (is_eq) begin m_compute(mR, res); mR = res; end
                    else if (is_as) begin mA = mR; mop = k - 10; mst = 1; end
                    else if (is_dig) begin
                        mA = k; mB = 0; mR = 0; mcnt = 1; movf = 0; mst = 0;
                    end
                end
            endcase
        end
    endtask

    function automatic exp_t m_expect();
        exp_t e;
        e.st  = mst;
        e.ovf = movf;
        e.err = merr;
        if (mst == 2)      begin e.disp = mB; e.src = 1; end
        else if (mst == 3) begin e.disp = mR; e.src = 2; end
        else               begin e.disp = mA; e.src = 0; end
        return e;
    endfunction

    // One clock of stimulus; the expected post-edge outputs go to the scoreboard
    task automatic step(input bit ca, input bit ce, input bit kv, input int k);
        @(negedge clk);
        clearAll       = ca;
        bus.clearEntry = ce;
        bus.key_valid  = kv;
        bus.key        = 4'(k);
        m_step(ca, ce, kv, k);
        q.push_back(m_expect());
    endtask

    task automatic press(input int k);
        step(1'b0, 1'b0, 1'b1, k);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_display",   int'($signed(bus.display)), e.disp);
            chk("sb_disp_src",  int'(bus.disp_src), e.src);
            chk("sb_state",     int'(bus.state), e.st);
            chk("sb_overflow",  int'(bus.overflow), e.ovf);
            chk("sb_entry_err", int'(bus.entry_err), e.err);
            chk("sb_zero",      int'(bus.zero), (e.disp == 0) ? 1 : 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        bus.key_valid  = 1'b0;
        bus.key        = 4'h0;
        bus.clearEntry = 1'b0;
        m_reset();

        do_reset();
        after_edge();
        chk("rst_display", int'($signed(bus.display)), 0);
        chk("rst_zero",    int'(bus.zero), 1);
        chk("rst_state",   int'(bus.state), 0);

        // 12 + 3 = 15
        do_reset(); press(1); press(2); press(10); press(3); press(13);
        after_edge();
        chk("add_display", int'($signed(bus.display)), 15);
        chk("add_state",   int'(bus.state), 3);
        chk("add_src",     int'(bus.disp_src), 2);
        chk("add_ovf",     int'(bus.overflow), 0);
        chk("add_zero",    int'(bus.zero), 0);

        // 127 + 1 overflows, repeat equals recovers
        do_reset(); press(1); press(2); press(7); press(10); press(1); press(13);
        after_edge();
        chk("ovf_display", int'($signed(bus.display)), -128);
        chk("ovf_flag",    int'(bus.overflow), 1);
        press(13);
        after_edge();
        chk("rep_display", int'($signed(bus.display)), -127);
        chk("rep_ovf",     int'(bus.overflow), 0);

        // 5 - 5 = 0, repeat -> -5, digit starts new entry
        do_reset(); press(5); press(11); press(5); press(13);
        after_edge();
        chk("sub_display", int'($signed(bus.display)), 0);
        chk("sub_zero",    int'(bus.zero), 1);
        press(13);
        after_edge();
        chk("sub_rep", int'($signed(bus.display)), -5);
        press(3);
        after_edge();
        chk("new_state",   int'(bus.state), 0);
        chk("new_display", int'($signed(bus.display)), 3);

        // Magnitude and digit-count rejection
        do_reset(); press(1); press(3); press(0);
        after_edge();
        chk("mag_display", int'($signed(bus.display)), 13);
        chk("mag_err",     int'(bus.entry_err), 1);
        step(1'b0, 1'b0, 1'b0, 0);
        after_edge();
        chk("mag_err_pulse", int'(bus.entry_err), 0);
        do_reset(); press(1); press(2); press(3); press(4);
        after_edge();
        chk("cnt_display", int'($signed(bus.display)), 123);
        chk("cnt_err",     int'(bus.entry_err), 1);

        // Negated operands
        do_reset(); press(9); press(14); press(10); press(4); press(14); press(13);
        after_edge();
        chk("neg_display", int'($signed(bus.display)), -13);

        // clearEntry wins over a coincident key in ENTER_B
        do_reset(); press(9); press(10); press(4);
        step(1'b0, 1'b1, 1'b1, 7);
        after_edge();
        chk("ce_state",   int'(bus.state), 1);
        chk("ce_display", int'($signed(bus.display)), 9);

        // clearAll wins over a coincident key in ENTER_B
        do_reset(); press(9); press(10); press(4);
        step(1'b1, 1'b0, 1'b1, 7);
        after_edge();
        chk("ca_display", int'($signed(bus.display)), 0);
        chk("ca_state",   int'(bus.state), 0);
        chk("ca_src",     int'(bus.disp_src), 0);
        chk("ca_zero",    int'(bus.zero), 1);

        // Randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 1)       step(1'b1, 1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 15));
            else if (r < 6)  step(1'b0, 1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 15));
            else if (r < 25) step(1'b0, 1'b0, 1'b0, $urandom_range(0, 15));
            else if (r < 65) press($urandom_range(0, 9));
            else             press($urandom_range(0, 15));
        end

        step(1'b0, 1'b0, 1'b0, 0);
        after_edge();
        chk("sb_drain", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/calc_engine.md
CALC_ENGINE -- requirements
Module: calc_engine

Interface
REQ-001 Parameter W, default 8: operand/result width, two's complement, range -2^(W-1)..2^(W-1)-1.
REQ-002 Parameter MAX_DIGITS, default 3: maximum decimal digits accepted per operand entry.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 clearAll  input  1  reset; synchronous, active-high.
REQ-005 clearEntry  input  1  synchronous clear of the operand currently being entered.
REQ-006 key_valid  input  1  one-cycle strobe; key is valid this cycle.
REQ-007 key  input  4  key code: 0x0-0x9 digit, 0xA add, 0xB subtract, 0xD equals, 0xE negate, 0xC/0xF ignored.
REQ-008 display  output  W  signed value selected for the output unit.
REQ-009 disp_src  output  2  display source: 0 operand A, 1 operand B, 2 result.
REQ-010 state  output  2  FSM state code: 0 ENTER_A, 1 OP_WAIT, 2 ENTER_B, 3 RESULT.
REQ-011 overflow  output  1  signed overflow of last computed result.
REQ-012 zero  output  1  high when display equals 0.
REQ-013 entry_err  output  1  one-cycle pulse when a digit or negate key is rejected.

Function
REQ-014 All registered outputs SHALL update on the edge following the key_valid cycle (latency 1); key_valid low SHALL leave all state unchanged.
REQ-015 Priority SHALL be clearAll > clearEntry > key_valid; a key coinciding with clearEntry SHALL be dropped.
REQ-016 Digit entry SHALL compute new = 10*|entry| + digit (shift-add, no multiplier) and apply the entry sign.
REQ-017 A digit SHALL be rejected (state unchanged, entry_err pulse) if digit count would exceed MAX_DIGITS or new magnitude exceeds 2^(W-1)-1.
REQ-018 Negate SHALL toggle the sign of the current entry; negate on value 0, in OP_WAIT, or in RESULT SHALL be ignored with no entry_err.
REQ-019 ENTER_A: digit/negate edit A; add/sub latch op, go OP_WAIT; equals ignored; display=A, disp_src=0.
REQ-020 OP_WAIT: digit loads B=digit, go ENTER_B; add/sub replace pending op; equals ignored; display=A, disp_src=0.
REQ-021 ENTER_B: digit/negate edit B; equals computes R=A op B, go RESULT; add/sub compute R, set A=R, latch new op, go OP_WAIT (chaining); display=B, disp_src=1.
REQ-022 RESULT: equals repeats last op with stored B (R=R op B); add/sub set A=R, latch op, go OP_WAIT; digit clears A,B,R, loads A=digit, go ENTER_A; display=R, disp_src=2.
REQ-023 Arithmetic SHALL be W-bit two's complement, result wrapped modulo 2^W; overflow = operands' signs equal (after negating B for subtract) and result sign differs.
REQ-024 overflow SHALL be written on every compute and cleared on any digit key or clearEntry; zero SHALL be combinational from display.
REQ-025 clearEntry: ENTER_A clears A and digit count; OP_WAIT/ENTER_B clears B, keeps A and op, goes OP_WAIT; RESULT behaves as clearAll.
REQ-026 Digit counter SHALL reset on every transition into an entry state and count only accepted digits.

Reset
REQ-027 On clearAll: A=B=R=0, op=add, state=ENTER_A, display=0, disp_src=0, overflow=0, entry_err=0, zero=1, effective next edge, from any state including mid-entry.

Verification
REQ-028 Keys 1,2,A,3,D -> display=15, state=3, disp_src=2, overflow=0, zero=0.
REQ-029 Keys 1,2,7,A,1,D -> display=0x80 (-128), overflow=1; then D -> display=0x81 (-127), overflow=0.
REQ-030 Keys 5,B,5,D -> display=0, zero=1; then D -> display=0xFB (-5); then 3 -> state=0, display=3.
REQ-031 Keys 1,3,0 -> 130 rejected, display=13, entry_err high one cycle; keys 1,2,3,4 from reset -> 4th rejected, display=123.
REQ-032 Keys 9,E,A,4,E,D -> A=-9, B=-4, display=0xF3 (-13); clearEntry same cycle as key 7 in ENTER_B -> B=0, state=1, key dropped.
REQ-033 clearAll asserted during ENTER_B with key_valid high -> next edge all outputs at reset values, key dropped.
